// File: rtl/addr_calc_arbiter_if.sv
// Bundled request, config, result and statistics signals of addr_calc_arbiter.
interface addr_calc_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_address;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_address;
  logic [7:0]  req1_b;
  logic        cfg_we;
  logic        cfg_sel;
  logic [7:0]  cfg_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_count;
  logic        out_id;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  modport slave (
    input  req0_valid, req0_address, req0_b,
    input  req1_valid, req1_address, req1_b,
    input  cfg_we, cfg_sel, cfg_wdata, out_ready,
    output req0_ready, req1_ready, out_valid, out_count, out_id,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_address, req0_b,
    output req1_valid, req1_address, req1_b,
    output cfg_we, cfg_sel, cfg_wdata, out_ready,
    input  req0_ready, req1_ready, out_valid, out_count, out_id,
    input  grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/addr_calc_arbiter.sv
// Round-robin shared two-stage datapath: count = address - (BASE - ptr) + b.
// Define ADDR_CALC_STATS_EN to build the saturating per-client grant counters.
module addr_calc_arbiter #(
  parameter logic [7:0] BASE = 8'h80
) (
  input  logic               clk,
  input  logic               rst_n,
  addr_calc_arbiter_if.slave bus
);

  logic [7:0]  ptr0_q, ptr1_q;
  logic        last_grant_q, last_grant_d;
  logic        s1_valid_q;
  logic [7:0]  s1_addr_q, s1_b_q, s1_ptr_q;
  logic        s1_id_q;
  logic        out_valid_q;
  logic [15:0] out_count_q, count_d;
  logic        out_id_q;

  logic grant0, grant1, s1_en, s2_en, acc0, acc1, accept;
  logic [7:0]  offset;

  assign s2_en  = !out_valid_q || bus.out_ready;
  assign s1_en  = !s1_valid_q || s2_en;

  // last_grant = 1 after reset lets client 0 win the first contention.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

  assign bus.req0_ready = grant0 && s1_en;
  assign bus.req1_ready = grant1 && s1_en;
  assign acc0   = bus.req0_valid && bus.req0_ready;
  assign acc1   = bus.req1_valid && bus.req1_ready;
  assign accept = acc0 || acc1;

  always_comb begin
    last_grant_d = last_grant_q;
    if (acc0)      last_grant_d = 1'b0;
    else if (acc1) last_grant_d = 1'b1;
  end

  assign offset  = BASE - s1_ptr_q;
  assign count_d = {8'h00, s1_addr_q} - {8'h00, offset} + {8'h00, s1_b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr0_q       <= BASE;
      ptr1_q       <= BASE;
      last_grant_q <= 1'b1;
    end else begin
      if (bus.cfg_we && !bus.cfg_sel) ptr0_q <= bus.cfg_wdata;
      if (bus.cfg_we &&  bus.cfg_sel) ptr1_q <= bus.cfg_wdata;
      last_grant_q <= last_grant_d;
    end
  end

  // S1 samples the pointer before any same-edge cfg write, so a colliding grant sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_b_q     <= '0;
      s1_ptr_q   <= '0;
      s1_id_q    <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= acc1 ? bus.req1_address : bus.req0_address;
        s1_b_q    <= acc1 ? bus.req1_b       : bus.req0_b;
        s1_ptr_q  <= acc1 ? ptr1_q           : ptr0_q;
        s1_id_q   <= acc1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_id_q    <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_count_q <= count_d;
        out_id_q    <= s1_id_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_id    = out_id_q;

`ifdef ADDR_CALC_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && cnt0_q != '1) cnt0_q <= cnt0_q + 16'd1;
      if (acc1 && cnt1_q != '1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;
`else
  assign bus.grant_cnt0 = '0;
  assign bus.grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_addr_calc_arbiter.sv
// Directed bench for addr_calc_arbiter: vector table plus multi-cycle sequences.
module tb_addr_calc_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addr_calc_arbiter_if bus();

  addr_calc_arbiter #(.BASE(8'h80)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        sel;
    logic [7:0]  ptr;
    logic [7:0]  address;
    logic [7:0]  b;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [8];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef ADDR_CALC_STATS_EN
  localparam logic [15:0] EXP_CNT0 = 16'd3;
  localparam logic [15:0] EXP_CNT1 = 16'd2;
`else
  localparam logic [15:0] EXP_CNT0 = 16'd0;
  localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] data);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_wdata = data;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b);
    logic done;
    done = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_address = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_address = a; bus.req0_b = b; end
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      done = id ? bus.req1_ready : bus.req0_ready;
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (!done) check("send_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_out(input string name, input logic [15:0] exp_count, input logic exp_id);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        check({name, "_count"}, bus.out_count, exp_count);
        check({name, "_id"}, {15'd0, bus.out_id}, {15'd0, exp_id});
      end
      step();
    end
    if (!seen) check({name, "_timeout"}, 16'd0, 16'd1);
  endtask

  initial begin
    logic [1:0] exp_rdy;
    logic       ids[$];
    int         i0, i1, acc_stall, n_out, first_id;
    logic       h0, h1;

    vecs[0] = '{1'b0, 8'h80, 8'h10, 8'h05, 16'h0015};
    vecs[1] = '{1'b1, 8'h00, 8'h00, 8'h90, 16'h0010};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 16'hFF80};
    vecs[3] = '{1'b0, 8'h70, 8'h10, 8'h00, 16'h0000};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h00, 16'hFF7F};
    vecs[5] = '{1'b1, 8'h81, 8'hFF, 8'hFF, 16'h00FF};
    vecs[6] = '{1'b0, 8'h80, 8'hFF, 8'hFF, 16'h01FE};
    vecs[7] = '{1'b1, 8'h01, 8'h7F, 8'h01, 16'h0001};

    bus.req0_valid = 1'b0; bus.req0_address = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_address = '0; bus.req1_b = '0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_wdata = '0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_ready",     {14'd0, bus.req1_ready, bus.req0_ready}, 16'd0);
    check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_out_count", bus.out_count, 16'd0);
    check("rst_out_id",    {15'd0, bus.out_id}, 16'd0);
    check("rst_cnt0",      bus.grant_cnt0, 16'd0);
    check("rst_cnt1",      bus.grant_cnt1, 16'd0);
    rst_n = 1'b1;
    step();

    // Contention: both valid for six cycles, grants and result ids alternate from client 0.
    bus.req0_address = 8'h01; bus.req0_b = 8'h00;
    bus.req1_address = 8'h02; bus.req1_b = 8'h00;
    for (int i = 0; i < 10; i++) begin
      bus.req0_valid = (i < 6);
      bus.req1_valid = (i < 6);
      #1;
      if (i < 6) begin
        exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
        check($sformatf("cont_grant%0d", i), {14'd0, bus.req1_ready, bus.req0_ready}, {14'd0, exp_rdy});
      end
      if (bus.out_valid) ids.push_back(bus.out_id);
      step();
    end
    check("cont_nres", ids.size(), 16'd6);
    for (int k = 0; k < ids.size(); k++)
      check($sformatf("cont_id%0d", k), {15'd0, ids[k]}, (k % 2 == 0) ? 16'd0 : 16'd1);

    // Latency: result is not visible after the accept edge, visible one edge later.
    send(1'b0, 8'h10, 8'h05);
    check("lat_s1_only", {15'd0, bus.out_valid}, 16'd0);
    step();
    check("lat_valid", {15'd0, bus.out_valid}, 16'd1);
    check("lat_count", bus.out_count, 16'h0015);
    step();

    for (int v = 0; v < 8; v++) begin
      cfg_write(vecs[v].sel, vecs[v].ptr);
      send(vecs[v].sel, vecs[v].address, vecs[v].b);
      wait_out($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].sel);
    end

    // Config write colliding with a req0 grant: that grant still uses ptr0 = 0x80.
    cfg_write(1'b0, 8'h80);
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_wdata = 8'h70;
    bus.req0_valid = 1'b1; bus.req0_address = 8'h10; bus.req0_b = 8'h00;
    #1;
    check("coll_ready", {15'd0, bus.req0_ready}, 16'd1);
    step();
    bus.cfg_we = 1'b0; bus.req0_valid = 1'b0;
    wait_out("coll_old", 16'h0010, 1'b0);
    send(1'b0, 8'h10, 8'h00);
    wait_out("coll_new", 16'h0000, 1'b0);

    // Backpressure: both stream, out_ready low for four cycles, then drain in order.
    cfg_write(1'b0, 8'h80);
    cfg_write(1'b1, 8'h80);
    bus.out_ready = 1'b0;
    i0 = 0; i1 = 0; acc_stall = 0; n_out = 0; first_id = 1;
    bus.req0_b = 8'h00; bus.req1_b = 8'h00;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      bus.out_ready  = (c >= 4);
      bus.req0_valid = (i0 + i1 < 6);
      bus.req1_valid = (i0 + i1 < 6);
      bus.req0_address = 8'h20 + 8'(i0);
      bus.req1_address = 8'h30 + 8'(i1);
      #1;
      h0 = bus.req0_valid && bus.req0_ready;
      h1 = bus.req1_valid && bus.req1_ready;
      if (c < 4 && (h0 || h1)) acc_stall++;
      if (c == 3) begin
        check("bp_ready_low", {14'd0, bus.req1_ready, bus.req0_ready}, 16'd0);
        check("bp_hold_count", bus.out_count, 16'h0030);
        check("bp_hold_id", {15'd0, bus.out_id}, 16'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp_id%0d", n_out), {15'd0, bus.out_id},
              16'((first_id + n_out) % 2));
        check($sformatf("bp_count%0d", n_out), bus.out_count,
              (((first_id + n_out) % 2) == 1) ? 16'h0030 + 16'(n_out / 2)
                                               : 16'h0020 + 16'(n_out / 2));
        n_out++;
      end
      step();
      if (h0) i0++;
      if (h1) i1++;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("bp_stall_acc", acc_stall, 16'd2);
    check("bp_nout", n_out, 16'd6);
    bus.out_ready = 1'b1;
    step();

    // Reset with both stages full: out_valid drops before any clock edge.
    bus.out_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    step();
    step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("mid_full", {15'd0, bus.out_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("mid_cnt0", bus.grant_cnt0, 16'd0);
    check("mid_cnt1", bus.grant_cnt1, 16'd0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("mid_first_grant", {14'd0, bus.req1_ready, bus.req0_ready}, 16'd1);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();
    check("mid_no_result", {15'd0, bus.out_valid}, 16'd0);

    // Statistics: three client-0 and two client-1 acceptances.
    for (int k = 0; k < 3; k++) begin
      send(1'b0, 8'h40 + 8'(k), 8'h01);
      wait_out($sformatf("st0_%0d", k), 16'h0041 + 16'(k), 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      send(1'b1, 8'h50 + 8'(k), 8'h02);
      wait_out($sformatf("st1_%0d", k), 16'h0052 + 16'(k), 1'b1);
    end
    check("stat_cnt0", bus.grant_cnt0, EXP_CNT0);
    check("stat_cnt1", bus.grant_cnt1, EXP_CNT1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
